// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops words from the fifo read port and sends each one as a UART frame on tx
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tx_en,
    input  logic                  rd_val,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_en,
    output logic                  tx,
    output logic                  busy
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int NW = $clog2(DATA_WIDTH) + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [NW-1:0] DATA_LAST = NW'(DATA_WIDTH - 1);
    localparam logic [NW-1:0] STOP_LAST = NW'(STOP_BITS - 1);
    localparam logic ODD = (PARITY == 2);
    typedef enum logic [2:0] {IDLE, FETCH, START, DATA, PAR, STOP} state_t;
    state_t                state;
    logic [BW-1:0]         baud;
    logic [NW-1:0]         nbit;
    logic [DATA_WIDTH-1:0] shift;
    logic                  par_bit;
    logic                  last_clk;
    assign rd_en    = (state == IDLE) & tx_en & rd_val;
    assign last_clk = baud == BAUD_LAST;
    // frame sequencer: pop, latch word, then shift start/data/parity/stop bits out on tx
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            tx      <= 1'b1;
            busy    <= 1'b0;
            baud    <= '0;
            nbit    <= '0;
            shift   <= '0;
            par_bit <= 1'b0;
        end else begin
            case (state)
                IDLE: if (rd_en) begin
                    state <= FETCH;
                    busy  <= 1'b1;
                end
                FETCH: begin
                    shift   <= rd_data;
                    par_bit <= (^rd_data) ^ ODD;
                    state   <= START;
                    tx      <= 1'b0;
                    baud    <= '0;
                end
                START: if (last_clk) begin
                    baud  <= '0;
                    nbit  <= '0;
                    state <= DATA;
                    tx    <= shift[0];
                    shift <= shift >> 1;
                end else baud <= baud + 1'b1;
                DATA: if (last_clk) begin
                    baud <= '0;
                    if (nbit == DATA_LAST) begin
                        nbit  <= '0;
                        state <= (PARITY != 0) ? PAR : STOP;
                        tx    <= (PARITY != 0) ? par_bit : 1'b1;
                    end else begin
                        nbit  <= nbit + 1'b1;
                        tx    <= shift[0];
                        shift <= shift >> 1;
                    end
                end else baud <= baud + 1'b1;
                PAR: if (last_clk) begin
                    baud  <= '0;
                    state <= STOP;
                    tx    <= 1'b1;
                end else baud <= baud + 1'b1;
                STOP: if (last_clk) begin
                    baud <= '0;
                    if (nbit == STOP_LAST) begin
                        nbit  <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else nbit <= nbit + 1'b1;
                end else baud <= baud + 1'b1;
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
